// File: rtl/sum_feeder_if.sv
// Bus bundle for sum_feeder: CSR slave port (s_*) and Avalon-MM master port (m_*).
// The master modport is the feeder's view; the slave modport is the CPU/memory side.
interface sum_feeder_if;
  logic [1:0]  s_address;
  logic        s_read;
  logic [31:0] s_readdata;
  logic        s_write;
  logic [31:0] s_writedata;

  logic [31:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic [31:0] m_readdata;
  logic        m_waitrequest;

  modport master (
    input  s_address, s_read, s_write, s_writedata, m_readdata, m_waitrequest,
    output s_readdata, m_address, m_read, m_write, m_writedata, m_byteenable
  );

  modport slave (
    output s_address, s_read, s_write, s_writedata, m_readdata, m_waitrequest,
    input  s_readdata, m_address, m_read, m_write, m_writedata, m_byteenable
  );
endinterface

// File: rtl/sum_feeder.sv
// Avalon-MM master that clears the byte-sum accumulator, streams LEN words from SRC into it,
// and latches the final sum into RESULT. CPU-facing CSRs: SRC, LEN, CTRL/STATUS, RESULT.
module sum_feeder #(
  parameter logic [31:0] ACC_BASE = 32'h0000_1000,
  parameter int          LEN_W    = 16
) (
  input  logic          clk,
  input  logic          reset,
  sum_feeder_if.master  bus
);

  // state     | meaning
  // ST_IDLE   | no transfer, master strobes low
  // ST_CLEAR  | writing 0 to the accumulator clear word
  // ST_FETCH  | reading source word at ptr
  // ST_PUSH   | writing the fetched word into the accumulator
  // ST_RESULT | reading back the accumulated sum
  typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_FETCH, ST_PUSH, ST_RESULT} state_t;

  state_t           state_q, state_d;
  logic [31:0]      src_q, src_d, ptr_q, ptr_d, word_q, word_d, result_q, result_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [31:0]      m_address_q, m_address_d, m_writedata_q, m_writedata_d;
  logic             m_read_q, m_read_d, m_write_q, m_write_d;
  logic             accept;

  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    ptr_d         = ptr_q;
    word_d        = word_q;
    result_d      = result_q;
    busy_d        = busy_q;
    done_d        = done_q;
    m_address_d   = 32'h0;
    m_writedata_d = 32'h0;
    m_read_d      = 1'b0;
    m_write_d     = 1'b0;
    accept        = (m_read_q | m_write_q) & ~bus.m_waitrequest;

    // busy is only low in ST_IDLE, so START here never collides with the state case below
    if (bus.s_write && !busy_q) begin
      case (bus.s_address)
        2'd0: src_d = {bus.s_writedata[31:2], 2'b00};
        2'd1: len_d = bus.s_writedata[LEN_W-1:0];
        2'd2: if (bus.s_writedata[0]) begin
          busy_d  = 1'b1;
          done_d  = 1'b0;
          cnt_d   = '0;
          ptr_d   = src_q;
          state_d = ST_CLEAR;
        end
        default: ;
      endcase
    end

    case (state_q)
      ST_CLEAR: if (accept) state_d = (len_q != '0) ? ST_FETCH : ST_RESULT;
      ST_FETCH: if (accept) begin
        word_d  = bus.m_readdata;
        state_d = ST_PUSH;
      end
      ST_PUSH: if (accept) begin
        if (cnt_q == len_q - LEN_W'(1)) begin
          state_d = ST_RESULT;
        end else begin
          cnt_d   = cnt_q + LEN_W'(1);
          ptr_d   = ptr_q + 32'd4;
          state_d = ST_FETCH;
        end
      end
      ST_RESULT: if (accept) begin
        result_d = bus.m_readdata;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_IDLE: ;
      default: state_d = ST_IDLE;
    endcase

    // Strobes are decoded from the next state so they are registered and hold through stalls
    case (state_d)
      ST_CLEAR: begin
        m_write_d   = 1'b1;
        m_address_d = ACC_BASE + 32'd4;
      end
      ST_FETCH: begin
        m_read_d    = 1'b1;
        m_address_d = ptr_d;
      end
      ST_PUSH: begin
        m_write_d     = 1'b1;
        m_address_d   = ACC_BASE;
        m_writedata_d = word_d;
      end
      ST_RESULT: begin
        m_read_d    = 1'b1;
        m_address_d = ACC_BASE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      src_q         <= 32'h0;
      len_q         <= '0;
      cnt_q         <= '0;
      ptr_q         <= 32'h0;
      word_q        <= 32'h0;
      result_q      <= 32'h0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      m_address_q   <= 32'h0;
      m_writedata_q <= 32'h0;
      m_read_q      <= 1'b0;
      m_write_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      ptr_q         <= ptr_d;
      word_q        <= word_d;
      result_q      <= result_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      m_address_q   <= m_address_d;
      m_writedata_q <= m_writedata_d;
      m_read_q      <= m_read_d;
      m_write_q     <= m_write_d;
    end
  end

  assign bus.m_address    = m_address_q;
  assign bus.m_writedata  = m_writedata_q;
  assign bus.m_read       = m_read_q;
  assign bus.m_write      = m_write_q;
  assign bus.m_byteenable = (m_read_q | m_write_q) ? 4'hF : 4'h0;

  always_comb begin
    bus.s_readdata = 32'h0;
    if (bus.s_read) begin
      case (bus.s_address)
        2'd0:    bus.s_readdata = src_q;
        2'd1:    bus.s_readdata = 32'(len_q);
        2'd2:    bus.s_readdata = {30'b0, done_q, busy_q};
        default: bus.s_readdata = result_q;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_feeder.sv
// Self-checking bench for sum_feeder: memory + byte-sum accumulator responder with stalls,
// and a transaction-level reference of the expected bus sequence, latency and RESULT.
module tb_sum_feeder;
  localparam logic [31:0] ACC_BASE = 32'h0000_1000;
  localparam int          LEN_W    = 16;

  typedef struct packed {
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
  } txn_t;

  logic clk = 1'b0;
  logic reset;
  sum_feeder_if bif ();

  sum_feeder #(.ACC_BASE(ACC_BASE), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] mem [logic [31:0]];
  txn_t        obs_q[$];
  txn_t        exp_q[$];
  logic [31:0] exp_src, exp_sum, acc;
  int          exp_len, stall_cfg, scnt;
  bit          held;
  logic [31:0] h_addr, h_wdata;
  logic        h_rd, h_wr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] byte_sum(input logic [31:0] w);
    return 32'(w[7:0]) + 32'(w[15:8]) + 32'(w[23:16]) + 32'(w[31:24]);
  endfunction

  // Memory and accumulator slave; every transfer is stalled stall_cfg cycles before acceptance
  always @(negedge clk) begin
    if (reset) begin
      scnt = 0;
      held = 0;
      bif.m_waitrequest = 1'b0;
    end else begin
      if (held) begin
        check_eq("stall_addr",  bif.m_address,   h_addr);
        check_eq("stall_read",  bif.m_read,      h_rd);
        check_eq("stall_write", bif.m_write,     h_wr);
        check_eq("stall_wdata", bif.m_writedata, h_wdata);
      end
      held = 0;
      bif.m_readdata = !bif.m_read ? 32'h0 :
                       (bif.m_address == ACC_BASE) ? acc : mem_word(bif.m_address);
      if (bif.m_read || bif.m_write) begin
        if (scnt < stall_cfg) begin
          bif.m_waitrequest = 1'b1;
          scnt++;
          held = 1;
          h_addr = bif.m_address; h_rd = bif.m_read; h_wr = bif.m_write; h_wdata = bif.m_writedata;
        end else begin
          bif.m_waitrequest = 1'b0;
          scnt = 0;
          check_eq("byteenable", bif.m_byteenable, 4'hF);
          check_eq("rw_exclusive", bif.m_read & bif.m_write, 1'b0);
          obs_q.push_back('{wr: bif.m_write, a: bif.m_address,
                            d: bif.m_write ? bif.m_writedata : bif.m_readdata});
          if (bif.m_write && bif.m_address == ACC_BASE + 32'd4) acc = 32'h0;
          else if (bif.m_write && bif.m_address == ACC_BASE) acc = acc + byte_sum(bif.m_writedata);
        end
      end else begin
        bif.m_waitrequest = 1'b0;
        scnt = 0;
      end
    end
  end

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bif.s_write = 1'b1; bif.s_address = a; bif.s_writedata = d;
    @(posedge clk);
    #1 bif.s_write = 1'b0;
  endtask

  task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bif.s_read = 1'b1; bif.s_address = a;
    #1 d = bif.s_readdata;
    bif.s_read = 1'b0;
  endtask

  task automatic program_job(input logic [31:0] src, input int len);
    for (int i = 0; i < len; i++) mem[src + 32'(4 * i)] = $urandom;
    csr_write(2'd0, src);
    csr_write(2'd1, 32'(len));
    exp_src = src;
    exp_len = len;
  endtask

  task automatic build_exp();
    logic [31:0] a, s;
    exp_q.delete();
    s = 32'h0;
    exp_q.push_back('{wr: 1'b1, a: ACC_BASE + 32'd4, d: 32'h0});
    for (int i = 0; i < exp_len; i++) begin
      a = exp_src + 32'(4 * i);
      exp_q.push_back('{wr: 1'b0, a: a, d: mem_word(a)});
      exp_q.push_back('{wr: 1'b1, a: ACC_BASE, d: mem_word(a)});
      s = s + byte_sum(mem_word(a));
    end
    exp_q.push_back('{wr: 1'b0, a: ACC_BASE, d: s});
    exp_sum = s;
  endtask

  task automatic launch();
    obs_q.delete();
    build_exp();
    csr_write(2'd2, 32'h1);
  endtask

  // exp_edges < 0 skips the latency comparison
  task automatic finish_job(input string tag, input int exp_edges);
    logic [31:0] st, res;
    int edges = 0;
    csr_read(2'd2, st);
    check_eq({tag, "_busy"}, st, 32'h1);
    while (!st[1] && edges < 2000) begin
      @(posedge clk);
      edges++;
      csr_read(2'd2, st);
    end
    check_eq({tag, "_status_done"}, st, 32'h2);
    if (exp_edges >= 0) check_eq({tag, "_latency"}, 65'(edges), 65'(exp_edges));
    csr_read(2'd3, res);
    check_eq({tag, "_result"}, res, exp_sum);
    check_eq({tag, "_txn_count"}, 65'(obs_q.size()), 65'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check_eq($sformatf("%s_txn%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  task automatic run_job(input string tag, input logic [31:0] src, input int len, input int stall);
    stall_cfg = stall;
    program_job(src, len);
    launch();
    finish_job(tag, (2 * len + 2) * (stall + 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] src;
    int len, stall, guard;
    reset = 1'b1;
    bif.s_address = 2'd0; bif.s_read = 1'b0; bif.s_write = 1'b0; bif.s_writedata = 32'h0;
    bif.m_readdata = 32'h0; bif.m_waitrequest = 1'b0;
    acc = 32'h0; stall_cfg = 0; scnt = 0; held = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_m_read", bif.m_read, 1'b0);
    check_eq("rst_m_write", bif.m_write, 1'b0);
    for (int a = 0; a < 4; a++) begin
      csr_read(2'(a), d);
      check_eq($sformatf("rst_csr%0d", a), d, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;

    // CSR behaviour while idle
    csr_write(2'd0, 32'h0000_0103);
    csr_read(2'd0, d);
    check_eq("src_align", d, 32'h0000_0100);
    csr_write(2'd1, 32'hABCD_0007);
    csr_read(2'd1, d);
    check_eq("len_trunc", d, 32'h0000_0007);
    csr_write(2'd3, 32'h1234_5678);
    csr_read(2'd3, d);
    check_eq("result_ro", d, 32'h0);

    // Basic sum from the worked example
    mem[32'h100] = 32'h0102_0304; mem[32'h104] = 32'h1010_1010; mem[32'h108] = 32'hFFFF_FFFF;
    stall_cfg = 0;
    csr_write(2'd0, 32'h100);
    csr_write(2'd1, 32'd3);
    exp_src = 32'h100; exp_len = 3;
    launch();
    finish_job("basic", 8);
    check_eq("basic_sum_const", exp_sum, 32'h446);

    run_job("zero_len", 32'h400, 0, 0);
    run_job("backpressure", 32'h500, 2, 2);
    run_job("wrap", 32'hFFFF_FFFC, 2, 0);

    // Busy protection: writes during a run are ignored
    stall_cfg = 2;
    program_job(32'h200, 3);
    launch();
    csr_write(2'd0, 32'hDEAD_0000);
    csr_write(2'd1, 32'd9);
    csr_write(2'd2, 32'h1);
    finish_job("busy_prot", -1);
    csr_read(2'd0, d);
    check_eq("busy_prot_src", d, 32'h200);
    csr_read(2'd1, d);
    check_eq("busy_prot_len", d, 32'd3);
    launch();
    finish_job("restart", 24);

    // Reset during the push of word 1
    stall_cfg = 0;
    program_job(32'h300, 3);
    launch();
    guard = 0;
    do begin
      @(negedge clk);
      #2;
      guard++;
    end while (!(bif.m_write && bif.m_address == ACC_BASE && bif.m_writedata == mem_word(32'h304))
               && guard < 100);
    check_eq("reset_push1_seen", 65'(guard < 100), 65'(1));
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_m_read", bif.m_read, 1'b0);
    check_eq("midrst_m_write", bif.m_write, 1'b0);
    for (int a = 0; a < 4; a++) begin
      csr_read(2'(a), d);
      check_eq($sformatf("midrst_csr%0d", a), d, 32'h0);
    end
    reset = 1'b0;
    run_job("after_reset", 32'h300, 3, 0);

    // Randomized jobs
    for (int j = 0; j < 8; j++) begin
      src   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & 32'hFFFF_FFFC);
      len   = $urandom_range(0, 6);
      stall = $urandom_range(0, 2);
      run_job($sformatf("rand%0d", j), src, len, stall);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
